// File: rtl/cpu_pkg.sv
// Shared definitions for the boot/run sequencer of cpu_core.
// Holds the 3-bit state encodings seen on state_out, the internal FSM state
// type, the program length header width and the core halt opcode.
package cpu_pkg;

    // Width of the little-endian program length header.
    localparam int LEN_W = 16;

    // Encoding of the core halt instruction ("jal x0, 0", a self-loop).
    localparam logic [31:0] HALT_OPCODE = 32'h0000_006F;

    // Externally visible state encodings.
    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_LEN_LO  = 3'd1;
    localparam logic [2:0] ENC_LEN_HI  = 3'd2;
    localparam logic [2:0] ENC_DATA    = 3'd3;
    localparam logic [2:0] ENC_WRITE   = 3'd4;
    localparam logic [2:0] ENC_RUN     = 3'd5;
    localparam logic [2:0] ENC_HALTED  = 3'd6;
    localparam logic [2:0] ENC_TIMEOUT = 3'd7;
    localparam logic [2:0] ENC_ERROR   = 3'd7;

    // Internal states. TIMEOUT and ERROR are distinct internally but share
    // the visible encoding 7. RESTART is a one-cycle run-preparation state
    // and is reported with the RUN encoding.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_LO  = 4'd1,
        S_LEN_HI  = 4'd2,
        S_DATA    = 4'd3,
        S_WRITE   = 4'd4,
        S_RUN     = 4'd5,
        S_HALTED  = 4'd6,
        S_TIMEOUT = 4'd7,
        S_RESTART = 4'd8,
        S_ERROR   = 4'd9
    } state_e;

    function automatic logic [2:0] state_enc(input state_e s);
        logic [2:0] enc;
        enc = ENC_IDLE;
        case (s)
            S_IDLE:    enc = ENC_IDLE;
            S_LEN_LO:  enc = ENC_LEN_LO;
            S_LEN_HI:  enc = ENC_LEN_HI;
            S_DATA:    enc = ENC_DATA;
            S_WRITE:   enc = ENC_WRITE;
            S_RUN:     enc = ENC_RUN;
            S_HALTED:  enc = ENC_HALTED;
            S_TIMEOUT: enc = ENC_TIMEOUT;
            S_RESTART: enc = ENC_RUN;
            S_ERROR:   enc = ENC_ERROR;
            default:   enc = ENC_IDLE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles four accepted stream bytes into one little-endian 32-bit word.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : restart assembly at byte 0 (held while not loading data)
//   accept_i       : a byte is consumed this cycle
//   byte_i         : the byte being consumed
//   word_o         : assembled word (complete once word_ready_o has fired)
//   word_ready_o   : high in the cycle the 4th byte of a word is consumed
module byte_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;

    // Shift right so that the first byte ends up in bits [7:0].
    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        if (clear_i) begin
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
        end else if (accept_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = {byte_i, word_q[31:8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = accept_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/prog_load_run_ctrl.sv
// Boot and run sequencer for cpu_core. Loads a length-prefixed byte stream
// into instruction memory as little-endian words while holding the core in
// reset, then releases the core and counts run cycles until halt or timeout.
// Ports:
//   clk_150_mhz, rst         : clock, synchronous active-high reset
//   load_start, run_start    : one-cycle command pulses (ignored while busy)
//   rx_byte/rx_valid/rx_ready: byte stream, accepted on rx_valid & rx_ready
//   imem_we/addr/wdata       : instruction memory write port
//   core_rst_n, core_halt    : core reset and halt indication
//   busy, done, timeout, err : status levels
//   state_out, run_cycles    : encoded state and RUN cycle count
// Stream handshake: a byte transfers on a rising edge where rx_valid and
// rx_ready are both high; rx_ready is decoded from the state register only.
module prog_load_run_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_CYCLES = 1000000,
    parameter int CNT_W      = 32
) (
    input  logic              clk_150_mhz,
    input  logic              rst,
    input  logic              load_start,
    input  logic              run_start,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [2:0]        state_out,
    output logic [CNT_W-1:0]  run_cycles
);

    localparam logic [LEN_W:0]   DEPTH_L   = (LEN_W + 1)'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_CYCLES - 1);

    state_e              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [CNT_W-1:0]    run_cycles_q;

    logic                accept;
    logic [LEN_W-1:0]    len_d;
    logic                len_bad;
    logic                last_word;
    logic [31:0]         word;
    logic                word_ready;

    assign accept    = rx_valid && rx_ready;
    // Full header value as it will be once the high byte is taken.
    assign len_d     = {rx_byte, len_q[7:0]};
    assign len_bad   = (len_d == '0) || ({1'b0, len_d} > DEPTH_L);
    assign last_word = (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)));

    byte_word_packer u_packer (
        .clk_i        (clk_150_mhz),
        .rst_i        (rst),
        .clear_i      (state_q != S_DATA && state_q != S_WRITE),
        .accept_i     (accept && state_q == S_DATA),
        .byte_i       (rx_byte),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_ff @(posedge clk_150_mhz) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start) state_q <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_byte;
                        state_q    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= rx_byte;
                        if (len_bad) begin
                            state_q <= S_ERROR;
                        end else begin
                            word_idx_q <= '0;
                            state_q    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_ready) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (last_word) begin
                        run_cycles_q <= '0;
                        state_q      <= S_RUN;
                    end else begin
                        word_idx_q <= word_idx_q + ADDR_W'(1);
                        state_q    <= S_DATA;
                    end
                end
                S_RUN: begin
                    // Halt takes priority over the cycle limit.
                    if (core_halt) begin
                        state_q <= S_HALTED;
                    end else if (run_cycles_q == RUN_LIMIT) begin
                        state_q <= S_TIMEOUT;
                    end else if (run_cycles_q != '1) begin
                        run_cycles_q <= run_cycles_q + CNT_W'(1);
                    end
                end
                S_HALTED, S_TIMEOUT: begin
                    if (load_start) begin
                        state_q <= S_LEN_LO;
                    end else if (run_start) begin
                        run_cycles_q <= '0;
                        state_q      <= S_RESTART;
                    end
                end
                S_ERROR: begin
                    if (load_start) state_q <= S_LEN_LO;
                end
                S_RESTART: begin
                    state_q <= S_RUN;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = imem_we ? word_idx_q : '0;
    assign imem_wdata = imem_we ? word : 32'd0;
    assign core_rst_n = (state_q == S_RUN) || (state_q == S_HALTED);
    assign busy       = rx_ready || imem_we || (state_q == S_RESTART) ||
                        (state_q == S_RUN);
    assign done       = (state_q == S_HALTED);
    assign timeout    = (state_q == S_TIMEOUT);
    assign err        = (state_q == S_ERROR);
    assign state_out  = state_enc(state_q);
    assign run_cycles = run_cycles_q;

endmodule

// File: doc/prog_load_run_ctrl.md
Name: prog_load_run_ctrl

Overview:
- Boot and run sequencer for cpu_core.
- Receives a length-prefixed program as a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into instruction memory.
- While loading, holds the core in reset. After loading, releases the core, counts run cycles, and stops on halt or timeout.
- Sits at SoC top between the host/UART byte source, the instruction memory write port and the core rst_n.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- MAX_CYCLES, 1000000, run-cycle limit before timeout; must be >= 1.
- CNT_W, 32, run-cycle counter width.

Ports:
- clk_150_mhz  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a program load.
- run_start  in  1  one-cycle pulse; re-runs the already-loaded program.
- rx_byte  in  8  stream byte.
- rx_valid  in  1  stream byte valid.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready at a clock edge.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word data.
- core_rst_n  out  1  active-low reset to cpu_core.
- core_halt  in  1  high while the core is executing the halt opcode.
- busy  out  1  high in LEN_LO, LEN_HI, DATA, WRITE, RESTART, RUN.
- done  out  1  level; high in HALTED.
- timeout  out  1  level; high in TIMEOUT.
- err  out  1  level; high in ERROR.
- state_out  out  3  encoded current state.
- run_cycles  out  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE, core_rst_n=0, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, run_cycles=0.
  - All flags 0.
- States and encodings: IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, WRITE=4, RUN=5, HALTED=6, TIMEOUT/ERROR=7.
  - ERROR and TIMEOUT share encoding 7; the err and timeout outputs distinguish them.
- IDLE:
  - load_start -> LEN_LO.
  - run_start is ignored, because no program is loaded.
- LEN_LO / LEN_HI:
  - rx_ready=1.
  - Each accepted byte fills len[7:0], then len[15:8].
  - On leaving LEN_HI: if len==0 or len>DEPTH -> ERROR; else -> DATA with word_idx=0, byte_idx=0.
- DATA:
  - rx_ready=1.
  - Accepted byte k (byte_idx 0..3) goes to word bits [8k+7:8k].
  - The 4th byte -> WRITE.
  - Stall indefinitely while rx_valid=0; there is no timeout on the stream.
- WRITE (one cycle):
  - rx_ready=0, imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
  - Next: if word_idx==len-1 -> RUN with run_cycles cleared to 0; else word_idx+1 -> DATA.
  - Each word therefore costs 4 handshakes + 1 cycle.
- core_rst_n=0 in every state except RUN and HALTED.
- RUN:
  - core_rst_n=1.
  - run_cycles increments every cycle, saturating at all-ones.
  - core_halt=1 -> HALTED; run_cycles does not increment in that cycle.
  - Else if run_cycles==MAX_CYCLES-1 -> TIMEOUT (core_rst_n=0 from the next cycle).
  - If halt and the limit occur in the same cycle, halt wins.
- HALTED:
  - core_rst_n stays 1; the core PC is frozen by its halt mux.
  - run_cycles is held.
- HALTED / TIMEOUT / ERROR exits:
  - load_start -> LEN_LO (reload).
  - run_start (not valid from ERROR) -> RESTART.
  - If both pulse together, load_start wins.
- RESTART (one cycle): core_rst_n=0, run_cycles cleared -> RUN.
- load_start and run_start are ignored while busy=1.
- rst mid-load or mid-run returns to IDLE immediately.
  - Partially written memory contents are not cleared; a reload overwrites them.
- rx_ready is a registered/state-decoded output; there is no combinational path from rx_valid.

Decomposition:
- Shared package cpu_pkg holds:
  - The state encoding localparams.
  - The length-header width (16).
  - The halt opcode constant used by the top-level core_halt decode.
- One natural sub-module: byte_word_packer, which holds byte_idx and the word shift register and outputs word_ready.
- The FSM and the counters stay in the top module.

Test Plan:
- Load 2 words: bytes 02 00 | 13 00 50 00 | FF 00 00 0C, rx_valid held high -> writes addr0=0x00500013, then addr1=0x0C0000FF; RUN entered 1 cycle after the 2nd write; core_rst_n rises then.
- With core_halt asserted 10 cycles into RUN -> done=1, run_cycles=10, core_rst_n stays 1; then run_start -> one cycle core_rst_n=0, then RUN with run_cycles counting from 0.
- Header len=0, and separately len=DEPTH+1 (0x0101 with ADDR_W=8) -> err=1, no imem_we pulse, core_rst_n=0.
- MAX_CYCLES=16, core_halt never asserted -> timeout=1 after exactly 16 RUN cycles, core_rst_n=0, run_cycles=15.
- rx_valid toggled randomly (gaps of 0-5 cycles) over 4 words -> words identical to the gap-free case, and no accept while rx_ready=0.
- rst pulsed during the 3rd byte of word 1 -> next cycle state=IDLE, all outputs at reset values; a subsequent full load succeeds.
